phase_diff: RTL and testbench

Computes the per-sample phase increment of the analytic signal produced by the Hilbert filter stage, and feeds `phase2speed` directly.
- Each accepted (I, Q) sample is converted to an angle by an iterative CORDIC in vectoring mode.
- The angle of the previous sample is subtracted, and the result is wrapped to (-π, π].
- The output is a 19-bit signed Q3.16 radian value with a one-cycle `ready` strobe, wired to the `phase`/`sample` inputs of `phase2speed`.

---
 rtl/phase_diff_if.sv | 25 ++
 rtl/phase_diff.sv | 169 ++++++++++++++++
 tb/tb_phase_diff.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/phase_diff_if.sv
// Sample/result bundle between the Hilbert filter, phase_diff and phase2speed.
// The master drives I/Q samples and the slave returns the wrapped phase increment.
interface phase_diff_if #(
   parameter int unsigned IW = 16
);
   localparam int unsigned PW = 19;

   logic                 sample;
   logic signed [IW-1:0] xi;
   logic signed [IW-1:0] xq;
   logic signed [PW-1:0] phase;
   logic                 ready;
   logic                 busy;
   logic                 overrun;

   modport master (
      output sample, xi, xq,
      input  phase, ready, busy, overrun
   );

   modport slave (
      input  sample, xi, xq,
      output phase, ready, busy, overrun
   );
endinterface

// File: rtl/phase_diff.sv
// Per-sample phase increment of an analytic signal: a vectoring CORDIC gives the
// angle, and the previous angle is subtracted and wrapped to (-pi, pi] in Q3.16.
module phase_diff #(
   parameter int unsigned IW   = 16,
   parameter int unsigned ITER = 16
) (
   input  logic        clock,
   input  logic        reset,
   phase_diff_if.slave bus
);
   localparam int unsigned XW = IW + 2;
   localparam int unsigned ZW = 19;
   localparam int unsigned DW = ZW + 1;
   localparam int unsigned CW = 4;

   localparam logic signed [ZW-1:0] PI       = 19'sd205887;
   localparam logic signed [DW-1:0] PI_D     = 20'sd205887;
   localparam logic signed [DW-1:0] TWO_PI_D = 20'sd411775;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_PREROT = 2'd1;
   localparam logic [1:0] ST_ITER   = 2'd2;
   localparam logic [1:0] ST_DIFF   = 2'd3;

   // atan(2^-i) in Q3.16, rounded
   function automatic logic signed [ZW-1:0] atan_rom(input logic [CW-1:0] idx);
      case (idx)
         4'd0:    atan_rom = 19'sd51472;
         4'd1:    atan_rom = 19'sd30386;
         4'd2:    atan_rom = 19'sd16055;
         4'd3:    atan_rom = 19'sd8150;
         4'd4:    atan_rom = 19'sd4091;
         4'd5:    atan_rom = 19'sd2047;
         4'd6:    atan_rom = 19'sd1024;
         4'd7:    atan_rom = 19'sd512;
         4'd8:    atan_rom = 19'sd256;
         4'd9:    atan_rom = 19'sd128;
         4'd10:   atan_rom = 19'sd64;
         4'd11:   atan_rom = 19'sd32;
         4'd12:   atan_rom = 19'sd16;
         4'd13:   atan_rom = 19'sd8;
         4'd14:   atan_rom = 19'sd4;
         default: atan_rom = 19'sd2;
      endcase
   endfunction

   logic [1:0]           state;
   logic [1:0]           state_nx;
   logic signed [XW-1:0] x;
   logic signed [XW-1:0] y;
   logic signed [ZW-1:0] z;
   logic signed [ZW-1:0] prev;
   logic signed [ZW-1:0] phase_q;
   logic [CW-1:0]        cnt;
   logic                 zero_in;
   logic                 first;
   logic                 ready_q;
   logic                 busy_q;
   logic                 overrun_q;

   logic signed [XW-1:0] x_sh_c;
   logic signed [XW-1:0] y_sh_c;
   logic signed [ZW-1:0] rom_c;
   logic                 dir_c;
   logic signed [ZW-1:0] angle_c;
   logic signed [DW-1:0] diff_raw_c;
   logic signed [DW-1:0] diff_c;

   // State register
   always_ff @(posedge clock) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:   if (bus.sample) state_nx = ST_PREROT;
         ST_PREROT: state_nx = ST_ITER;
         ST_ITER:   if (cnt == CW'(ITER - 1)) state_nx = ST_DIFF;
         ST_DIFF:   state_nx = ST_IDLE;
         default:   state_nx = ST_IDLE;
      endcase
   end

   // Micro-rotation terms and wrapped difference
   always_comb begin
      x_sh_c     = x >>> cnt;
      y_sh_c     = y >>> cnt;
      rom_c      = atan_rom(cnt);
      dir_c      = ~y[XW-1];
      angle_c    = zero_in ? prev : z;
      diff_raw_c = DW'(angle_c) - DW'(prev);
      diff_c     = diff_raw_c;
      if (diff_raw_c > PI_D) begin
         diff_c = diff_raw_c - TWO_PI_D;
      end else if (diff_raw_c <= -PI_D) begin
         diff_c = diff_raw_c + TWO_PI_D;
      end
   end

   // Datapath and registered outputs
   always_ff @(posedge clock) begin
      if (!reset) begin
         x         <= '0;
         y         <= '0;
         z         <= '0;
         prev      <= '0;
         phase_q   <= '0;
         cnt       <= '0;
         zero_in   <= 1'b0;
         first     <= 1'b1;
         ready_q   <= 1'b0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         busy_q  <= (state_nx != ST_IDLE);
         if (bus.sample && (state != ST_IDLE)) begin
            overrun_q <= 1'b1;
         end
         case (state)
            ST_IDLE: begin
               if (bus.sample) begin
                  x       <= XW'(bus.xi);
                  y       <= XW'(bus.xq);
                  zero_in <= (bus.xi == '0) && (bus.xq == '0);
                  cnt     <= '0;
               end
            end
            ST_PREROT: begin
               // Fold the left half-plane into the right so the CORDIC converges
               if (x[XW-1]) begin
                  x <= -x;
                  y <= -y;
                  z <= y[XW-1] ? -PI : PI;
               end else begin
                  z <= '0;
               end
            end
            ST_ITER: begin
               x   <= dir_c ? (x + y_sh_c) : (x - y_sh_c);
               y   <= dir_c ? (y - x_sh_c) : (y + x_sh_c);
               z   <= dir_c ? (z + rom_c) : (z - rom_c);
               cnt <= cnt + CW'(1);
            end
            ST_DIFF: begin
               prev <= angle_c;
               if (first) begin
                  first <= 1'b0;
               end else begin
                  phase_q <= ZW'(diff_c);
                  ready_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.phase   = phase_q;
   assign bus.ready   = ready_q;
   assign bus.busy    = busy_q;
   assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_phase_diff.sv
// Randomized scoreboard bench for phase_diff: an atan2-based model predicts each
// phase increment, and a monitor checks value, range and latency on every ready.
module tb_phase_diff;
   localparam int unsigned IW   = 16;
   localparam int unsigned ITER = 16;
   localparam int LAT      = ITER + 2;
   localparam int PI_I     = 205887;
   localparam int TWO_PI_I = 411775;
   localparam real PI_R    = 3.14159265358979 * 65536.0;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   cyc   = 0;

   phase_diff_if #(.IW(IW)) bus ();

   phase_diff #(.IW(IW), .ITER(ITER)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int exp;
      int tol;
      int cap;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   real  m_prev;
   bit   m_first;
   exp_t mon_e;
   int   mon_err;
   int   act;

   task automatic check(input string name, input int got, input int req);
      checks++;
      if (got != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, req, cyc);
      end
   endtask

   function automatic int wrap_i(input int v);
      if (v > PI_I) return v - TWO_PI_I;
      if (v <= -PI_I) return v + TWO_PI_I;
      return v;
   endfunction

   task automatic model_reset();
      m_prev  = 0.0;
      m_first = 1'b1;
      sb.delete();
   endtask

   // Exact-angle reference: difference of true atan2 angles wrapped to (-pi, pi]
   task automatic model(input int i, input int q, input int tol);
      real  a;
      real  d;
      exp_t e;
      if (i == 0 && q == 0) a = m_prev;
      else a = $atan2(real'(q), real'(i)) * 65536.0;
      if (m_first) begin
         m_first = 1'b0;
      end else begin
         d = a - m_prev;
         if (d > PI_R) d = d - 2.0 * PI_R;
         else if (d <= -PI_R) d = d + 2.0 * PI_R;
         e.exp = (d >= 0.0) ? $rtoi(d + 0.5) : $rtoi(d - 0.5);
         e.tol = tol;
         e.cap = cyc;
         sb.push_back(e);
      end
      m_prev = a;
   endtask

   task automatic send(input int i, input int q, input int tol);
      bus.sample = 1'b1;
      bus.xi     = IW'(i);
      bus.xq     = IW'(q);
      @(posedge clock);
      #1;
      bus.sample = 1'b0;
      model(i, q, tol);
   endtask

   task automatic wait_idle();
      bit done;
      done = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clock);
         if (!bus.busy) begin
            done = 1'b1;
            break;
         end
      end
      check("busy_fall_timeout", int'(done), 1);
      @(posedge clock);
      #1;
   endtask

   task automatic rand_vec(output int i, output int q);
      do begin
         i = int'($urandom_range(0, 64000)) - 32000;
         q = int'($urandom_range(0, 64000)) - 32000;
      end while (i * i + q * q < 256000000);
   endtask

   // Monitor: every ready must match the oldest outstanding prediction
   always @(negedge clock) begin
      if (reset && bus.ready) begin
         act = int'(bus.phase);
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ready: phase %0d with no result outstanding (cycle %0d)", act, cyc);
         end else begin
            mon_e   = sb.pop_front();
            mon_err = wrap_i(act - mon_e.exp);
            checks++;
            if (mon_err > mon_e.tol || mon_err < -mon_e.tol) begin
               errors++;
               $display("FAIL phase_value: got %0d, expected %0d +/-%0d", act, mon_e.exp, mon_e.tol);
            end
            check("latency", cyc - mon_e.cap, LAT);
            checks++;
            if (act <= -PI_I || act > PI_I) begin
               errors++;
               $display("FAIL phase_range: got %0d, required in (-%0d, %0d]", act, PI_I, PI_I);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int vi;
      int vq;
      bus.sample = 1'b0;
      bus.xi     = '0;
      bus.xq     = '0;
      model_reset();

      // Reset held low while sample toggles
      for (int k = 0; k < 3; k++) begin
         @(posedge clock);
         #1;
         bus.sample = ~bus.sample;
         bus.xi     = IW'(k * 1000 + 100);
         bus.xq     = IW'(k * 700 + 50);
         @(negedge clock);
         check("rst_phase", int'(bus.phase), 0);
         check("rst_ready", int'(bus.ready), 0);
         check("rst_busy", int'(bus.busy), 0);
         check("rst_overrun", int'(bus.overrun), 0);
      end
      @(posedge clock);
      #1;
      bus.sample = 1'b0;
      reset      = 1'b1;
      @(posedge clock);
      #1;

      // Quarter turn
      send(16384, 0, 8);
      check("busy_after_capture", int'(bus.busy), 1);
      wait_idle();
      send(0, 16384, 8);
      wait_idle();

      // Wrap-around across +/-pi
      send(-11585, 11585, 8);
      wait_idle();
      send(-11585, -11585, 8);
      wait_idle();

      // Zero vector keeps the previous angle
      send(8000, 8000, 4);
      wait_idle();
      send(0, 0, 4);
      wait_idle();
      send(8000, 8000, 4);
      wait_idle();

      // Random vectors, one at a time
      for (int k = 0; k < 20; k++) begin
         rand_vec(vi, vq);
         send(vi, vq, 128);
         wait_idle();
      end

      // Random vectors at full throughput: next sample in the ready cycle
      for (int k = 0; k < 10; k++) begin
         rand_vec(vi, vq);
         send(vi, vq, 128);
         repeat (LAT) @(posedge clock);
         #1;
      end
      wait_idle();
      check("overrun_clean", int'(bus.overrun), 0);

      // Overrun: sample 5 cycles into a conversion is dropped
      rand_vec(vi, vq);
      send(vi, vq, 128);
      repeat (5) @(posedge clock);
      #1;
      rand_vec(vi, vq);
      bus.sample = 1'b1;
      bus.xi     = IW'(vi);
      bus.xq     = IW'(vq);
      @(posedge clock);
      #1;
      bus.sample = 1'b0;
      check("overrun_set", int'(bus.overrun), 1);
      wait_idle();
      check("overrun_sticky", int'(bus.overrun), 1);
      rand_vec(vi, vq);
      send(vi, vq, 128);
      wait_idle();
      check("overrun_sticky2", int'(bus.overrun), 1);

      // Reset during ITER cycle 7 aborts the conversion
      rand_vec(vi, vq);
      send(vi, vq, 128);
      repeat (8) @(posedge clock);
      #1;
      reset = 1'b0;
      @(posedge clock);
      #1;
      reset = 1'b1;
      model_reset();
      check("abort_phase", int'(bus.phase), 0);
      check("abort_busy", int'(bus.busy), 0);
      check("abort_ready", int'(bus.ready), 0);
      check("abort_overrun", int'(bus.overrun), 0);
      repeat (25) @(posedge clock);
      #1;
      send(16384, 0, 8);
      wait_idle();
      send(0, 16384, 8);
      wait_idle();

      repeat (30) @(posedge clock);
      check("results_outstanding", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
